// File: rtl/axi_lite_timer_pkg.sv
// Shared constants, register offsets and types for the AXI-Lite timer.
// Offsets are byte addresses within the 4 KiB window; bits [1:0] are never decoded.
package axi_lite_timer_pkg;

  localparam logic [1:0]  RESP_OKAY    = 2'b00;
  localparam logic [1:0]  RESP_SLVERR  = 2'b10;

  localparam logic [11:0] OFF_CTRL     = 12'h000;
  localparam logic [11:0] OFF_PRESCALE = 12'h004;
  localparam logic [11:0] OFF_COUNT    = 12'h008;
  localparam logic [11:0] OFF_COMPARE  = 12'h00C;
  localparam logic [11:0] OFF_STATUS   = 12'h010;

  localparam logic [31:0] COMPARE_RST  = 32'hFFFF_FFFF;

  typedef struct packed {
    logic irq_en;
    logic auto_reload;
    logic en;
  } ctrl_t;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP} wstate_e;
  typedef enum logic       {R_IDLE, R_RESP} rstate_e;

  function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    return r;
  endfunction

  function automatic logic reg_known(input logic [11:0] off);
    return (off == OFF_CTRL) || (off == OFF_PRESCALE) || (off == OFF_COUNT) ||
           (off == OFF_COMPARE) || (off == OFF_STATUS);
  endfunction

endpackage

// File: rtl/axi_lite_timer.sv
// AXI4-Lite register front end plus prescaled 32-bit compare timer.
// Write and read channels run as independent FSMs; irq_o comes straight from a flop.
module axi_lite_timer
  import axi_lite_timer_pkg::*;
#(
  parameter int AXI_ADDR_BW_p = 16,
  parameter int AXI_DATA_BW_p = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [AXI_ADDR_BW_p-1:0]   s_axi_awaddr_i,
  input  logic                       s_axi_awvalid_i,
  output logic                       s_axi_awready_o,
  input  logic [AXI_DATA_BW_p-1:0]   s_axi_wdata_i,
  input  logic [AXI_DATA_BW_p/8-1:0] s_axi_wstrb_i,
  input  logic                       s_axi_wvalid_i,
  output logic                       s_axi_wready_o,
  output logic [1:0]                 s_axi_bresp_o,
  output logic                       s_axi_bvalid_o,
  input  logic                       s_axi_bready_i,
  input  logic [AXI_ADDR_BW_p-1:0]   s_axi_araddr_i,
  input  logic                       s_axi_arvalid_i,
  output logic                       s_axi_arready_o,
  output logic [AXI_DATA_BW_p-1:0]   s_axi_rdata_o,
  output logic [1:0]                 s_axi_rresp_o,
  output logic                       s_axi_rvalid_o,
  input  logic                       s_axi_rready_i,
  output logic                       irq_o
);

  wstate_e     w_state_q;
  rstate_e     r_state_q;
  logic [11:0] waddr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        bvalid_q, rvalid_q;
  logic [1:0]  bresp_q, rresp_q;
  logic [31:0] rdata_q;

  ctrl_t       ctrl_q, ctrl_d;
  logic [15:0] prescale_q, prescale_d, presc_cnt_q, presc_cnt_d;
  logic [31:0] count_q, count_d, compare_q, compare_d;
  logic        match_q, match_d, irq_q;

  // Sub-word and crossbar address bits are deliberately ignored.
  logic unused_addr;
  assign unused_addr = ^{s_axi_awaddr_i, s_axi_araddr_i};

  assign s_axi_awready_o = (w_state_q == W_IDLE) || (w_state_q == W_HAVE_DATA);
  assign s_axi_wready_o  = (w_state_q == W_IDLE) || (w_state_q == W_HAVE_ADDR);
  assign s_axi_arready_o = (r_state_q == R_IDLE);
  assign s_axi_bvalid_o  = bvalid_q;
  assign s_axi_bresp_o   = bresp_q;
  assign s_axi_rvalid_o  = rvalid_q;
  assign s_axi_rresp_o   = rresp_q;
  assign s_axi_rdata_o   = rdata_q;
  assign irq_o           = irq_q;

  logic        aw_hs, w_hs, wr_fire, wr_ok, cnt_wr, tick, hit;
  logic [11:0] wr_off;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;

  assign aw_hs   = s_axi_awvalid_i && s_axi_awready_o;
  assign w_hs    = s_axi_wvalid_i && s_axi_wready_o;
  // Live channel values win when the completing handshake happens this cycle.
  assign wr_off  = aw_hs ? {s_axi_awaddr_i[11:2], 2'b00} : waddr_q;
  assign wr_data = w_hs ? s_axi_wdata_i : wdata_q;
  assign wr_strb = w_hs ? s_axi_wstrb_i : wstrb_q;
  assign wr_fire = ((w_state_q == W_IDLE) && aw_hs && w_hs) ||
                   ((w_state_q == W_HAVE_ADDR) && w_hs) ||
                   ((w_state_q == W_HAVE_DATA) && aw_hs);
  assign wr_ok   = reg_known(wr_off);
  assign cnt_wr  = wr_fire && (wr_off == OFF_COUNT);
  assign tick    = ctrl_q.en && (presc_cnt_q == prescale_q);
  assign hit     = tick && !cnt_wr && (count_q == compare_q);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      w_state_q <= W_IDLE;
      waddr_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else if (wr_fire) begin
      w_state_q <= W_RESP;
      bvalid_q  <= 1'b1;
      bresp_q   <= wr_ok ? RESP_OKAY : RESP_SLVERR;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          if (aw_hs) begin
            waddr_q   <= {s_axi_awaddr_i[11:2], 2'b00};
            w_state_q <= W_HAVE_ADDR;
          end else if (w_hs) begin
            wdata_q   <= s_axi_wdata_i;
            wstrb_q   <= s_axi_wstrb_i;
            w_state_q <= W_HAVE_DATA;
          end
        end
        W_RESP: begin
          if (s_axi_bready_i) begin
            bvalid_q  <= 1'b0;
            w_state_q <= W_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  logic [31:0] rd_val;
  logic        rd_ok;

  always_comb begin
    rd_val = '0;
    rd_ok  = 1'b1;
    case ({s_axi_araddr_i[11:2], 2'b00})
      OFF_CTRL:     rd_val = {29'b0, ctrl_q};
      OFF_PRESCALE: rd_val = {16'b0, prescale_q};
      OFF_COUNT:    rd_val = count_q;
      OFF_COMPARE:  rd_val = compare_q;
      OFF_STATUS:   rd_val = {31'b0, match_q};
      default:      rd_ok  = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state_q <= R_IDLE;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          if (s_axi_arvalid_i) begin
            r_state_q <= R_RESP;
            rvalid_q  <= 1'b1;
            rdata_q   <= rd_val;
            rresp_q   <= rd_ok ? RESP_OKAY : RESP_SLVERR;
          end
        end
        R_RESP: begin
          if (s_axi_rready_i) begin
            r_state_q <= R_IDLE;
            rvalid_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ctrl_d      = ctrl_q;
    prescale_d  = prescale_q;
    count_d     = count_q;
    compare_d   = compare_q;
    presc_cnt_d = presc_cnt_q;
    match_d     = match_q;
    if (ctrl_q.en) presc_cnt_d = tick ? 16'd0 : presc_cnt_q + 16'd1;
    if (tick) count_d = (hit && ctrl_q.auto_reload) ? 32'd0 : count_q + 32'd1;
    if (wr_fire && wr_ok) begin
      case (wr_off)
        OFF_CTRL:     if (wr_strb[0]) ctrl_d = ctrl_t'(wr_data[2:0]);
        OFF_PRESCALE: begin
          if (wr_strb[0]) prescale_d[7:0]  = wr_data[7:0];
          if (wr_strb[1]) prescale_d[15:8] = wr_data[15:8];
        end
        OFF_COUNT: begin
          count_d     = apply_strb(count_q, wr_data, wr_strb);
          presc_cnt_d = 16'd0;
        end
        OFF_COMPARE:  compare_d = apply_strb(compare_q, wr_data, wr_strb);
        OFF_STATUS:   if (wr_strb[0] && wr_data[0]) match_d = 1'b0;
        default: ;
      endcase
    end
    // A hardware match beats a same-cycle software clear.
    if (hit) match_d = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ctrl_q      <= '0;
      prescale_q  <= '0;
      count_q     <= '0;
      compare_q   <= COMPARE_RST;
      presc_cnt_q <= '0;
      match_q     <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      ctrl_q      <= ctrl_d;
      prescale_q  <= prescale_d;
      count_q     <= count_d;
      compare_q   <= compare_d;
      presc_cnt_q <= presc_cnt_d;
      match_q     <= match_d;
      irq_q       <= match_d && ctrl_d.irq_en;
    end
  end

endmodule

// File: tb/tb_axi_lite_timer.sv
// Scoreboard bench for axi_lite_timer: expectations queued at issue, popped on response.
module tb_axi_lite_timer;
  import axi_lite_timer_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] awaddr = '0, araddr = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        awready, wready, bvalid, arready, rvalid, irq;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  int checks = 0;
  int failures = 0;

  typedef struct { logic [31:0] data; logic [1:0] resp; } rexp_t;
  rexp_t      rq[$];
  logic [1:0] bq[$];

  always #5 clk = ~clk;

  axi_lite_timer #(.AXI_ADDR_BW_p(16), .AXI_DATA_BW_p(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .s_axi_awaddr_i(awaddr), .s_axi_awvalid_i(awvalid), .s_axi_awready_o(awready),
    .s_axi_wdata_i(wdata), .s_axi_wstrb_i(wstrb), .s_axi_wvalid_i(wvalid), .s_axi_wready_o(wready),
    .s_axi_bresp_o(bresp), .s_axi_bvalid_o(bvalid), .s_axi_bready_i(bready),
    .s_axi_araddr_i(araddr), .s_axi_arvalid_i(arvalid), .s_axi_arready_o(arready),
    .s_axi_rdata_o(rdata), .s_axi_rresp_o(rresp), .s_axi_rvalid_o(rvalid), .s_axi_rready_i(rready),
    .irq_o(irq)
  );

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic axi_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output bit lat_ok);
    bit aw_p = 1, w_p = 1, aw_h, w_h;
    int n = 0;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
    while ((aw_p || w_p) && n < 50) begin
      aw_h = awvalid && awready;
      w_h  = wvalid && wready;
      step(); n++;
      if (aw_h) begin awvalid = 0; aw_p = 0; end
      if (w_h)  begin wvalid = 0;  w_p = 0;  end
    end
    awvalid = 0; wvalid = 0;
    lat_ok = bvalid;
    n = 0;
    while (!bvalid && n < 50) begin step(); n++; end
    if (!bvalid) begin
      checks++; failures++;
      $display("FAIL write_timeout addr=%h bvalid=%b required 1", a, bvalid);
    end
    resp = bresp; bready = 1; step(); bready = 0;
  endtask

  task automatic axi_read(input logic [15:0] a, output logic [31:0] d, output logic [1:0] r,
                          output bit lat_ok);
    bit h = 0;
    int n = 0;
    araddr = a; arvalid = 1;
    while (!h && n < 50) begin h = arready; step(); n++; end
    arvalid = 0;
    lat_ok = rvalid;
    n = 0;
    while (!rvalid && n < 50) begin step(); n++; end
    if (!rvalid) begin
      checks++; failures++;
      $display("FAIL read_timeout addr=%h rvalid=%b required 1", a, rvalid);
    end
    d = rdata; r = rresp; rready = 1; step(); rready = 0;
  endtask

  // Set-up writes whose responses are not the subject of a test.
  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    logic [1:0] r; bit l;
    axi_write(a, d, 4'hF, r, l);
  endtask

  task automatic test_reset();
    rst = 1; step(); step();
    checks++;
    if ({bvalid, rvalid, irq, bresp, rresp, awready, wready, arready} !== 10'b000_0000_111) begin
      failures++;
      $display("FAIL reset_outputs got=%b required=%b",
               {bvalid, rvalid, irq, bresp, rresp, awready, wready, arready}, 10'b000_0000_111);
    end
    checks++;
    if (rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h required=0", rdata); end
    rst = 0; step();
  endtask

  task automatic test_read_after_reset();
    logic [31:0] d; logic [1:0] r; bit l; rexp_t e;
    rq.push_back('{COMPARE_RST, RESP_OKAY});
    axi_read(16'h100C, d, r, l);
    e = rq.pop_front();
    checks++;
    if ({d, r} !== {e.data, e.resp}) begin
      failures++; $display("FAIL compare_reset_read got=%h/%b required=%h/%b", d, r, e.data, e.resp);
    end
    checks++;
    if (l !== 1'b1) begin failures++; $display("FAIL read_latency rvalid=%b required 1", l); end
  endtask

  task automatic test_w_before_aw();
    logic [31:0] d; logic [1:0] r; bit l; rexp_t e;
    bq.push_back(RESP_OKAY);
    wdata = 32'h1234; wstrb = 4'hF; wvalid = 1;
    step(); wvalid = 0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({bvalid, awready, wready} !== 3'b010) begin
        failures++; $display("FAIL have_data_state cyc=%0d got=%b required=010", i, {bvalid, awready, wready});
      end
      step();
    end
    awaddr = 16'h1008; awvalid = 1;
    step(); awvalid = 0;
    checks++;
    if ({bvalid, bresp} !== {1'b1, bq.pop_front()}) begin
      failures++; $display("FAIL w_first_bresp got=%b/%b required=1/00", bvalid, bresp);
    end
    bready = 1; step(); bready = 0;
    rq.push_back('{32'h1234, RESP_OKAY});
    axi_read(16'h1008, d, r, l);
    e = rq.pop_front();
    checks++;
    if ({d, r} !== {e.data, e.resp}) begin
      failures++; $display("FAIL count_readback got=%h/%b required=%h/%b", d, r, e.data, e.resp);
    end
  endtask

  task automatic test_wstrb();
    logic [31:0] d; logic [1:0] r; bit l; rexp_t e;
    axi_write(16'h100C, 32'h1122_3344, 4'b0101, r, l);
    axi_write(16'h1000, 32'h0000_0006, 4'b1110, r, l);
    rq.push_back('{32'hFF22_FF44, RESP_OKAY});
    rq.push_back('{32'h0, RESP_OKAY});
    axi_read(16'h100C, d, r, l);
    e = rq.pop_front();
    checks++;
    if ({d, r} !== {e.data, e.resp}) begin
      failures++; $display("FAIL compare_wstrb got=%h required=%h", d, e.data);
    end
    axi_read(16'h1000, d, r, l);
    e = rq.pop_front();
    checks++;
    if ({d, r} !== {e.data, e.resp}) begin
      failures++; $display("FAIL ctrl_wstrb got=%h required=%h", d, e.data);
    end
  endtask

  task automatic test_match_irq();
    logic [31:0] d; logic [1:0] r; bit l; rexp_t e;
    int cyc;
    wr(16'h1004, 32'd3);
    wr(16'h100C, 32'd5);
    wr(16'h1008, 32'd0);
    wr(16'h1000, 32'h7);
    cyc = 1;
    while (!irq && cyc < 100) begin step(); cyc++; end
    checks++;
    if (cyc !== 24) begin failures++; $display("FAIL irq_timing cycles=%0d required=24", cyc); end
    rq.push_back('{32'd0, RESP_OKAY});
    axi_read(16'h1008, d, r, l);
    e = rq.pop_front();
    checks++;
    if ({d, r} !== {e.data, e.resp}) begin
      failures++; $display("FAIL autoreload_count got=%h required=%h", d, e.data);
    end
    wr(16'h1000, 32'h4);
    axi_write(16'h1010, 32'h1, 4'h2, r, l);
    rq.push_back('{32'd1, RESP_OKAY});
    axi_read(16'h1010, d, r, l);
    e = rq.pop_front();
    checks++;
    if ({d, r, irq} !== {e.data, e.resp, 1'b1}) begin
      failures++; $display("FAIL status_no_strb_clear got=%h irq=%b required=%h irq=1", d, irq, e.data);
    end
    axi_write(16'h1010, 32'h1, 4'h1, r, l);
    rq.push_back('{32'd0, RESP_OKAY});
    axi_read(16'h1010, d, r, l);
    e = rq.pop_front();
    checks++;
    if ({d, r, irq} !== {e.data, e.resp, 1'b0}) begin
      failures++; $display("FAIL status_w1c got=%h irq=%b required=%h irq=0", d, irq, e.data);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] d, d2; logic [1:0] r, r2, rw; bit l, l2; rexp_t e;
    wr(16'h1000, 32'h0);
    wr(16'h1004, 32'h0);
    wr(16'h100C, 32'h10);
    wr(16'h1008, 32'hFFFF_FFFF);
    wr(16'h1000, 32'h1);
    rq.push_back('{32'd0, RESP_OKAY});
    fork
      axi_write(16'h1000, 32'h0, 4'hF, rw, l2);
      axi_read(16'h1008, d, r, l);
    join
    e = rq.pop_front();
    checks++;
    if ({d, r} !== {e.data, e.resp}) begin
      failures++; $display("FAIL wrap_first got=%h required=%h", d, e.data);
    end
    rq.push_back('{32'd1, RESP_OKAY});
    rq.push_back('{32'd0, RESP_OKAY});
    axi_read(16'h1008, d, r, l);
    axi_read(16'h1010, d2, r2, l2);
    e = rq.pop_front();
    checks++;
    if ({d, r} !== {e.data, e.resp}) begin
      failures++; $display("FAIL wrap_second got=%h required=%h", d, e.data);
    end
    e = rq.pop_front();
    checks++;
    if ({d2, r2} !== {e.data, e.resp}) begin
      failures++; $display("FAIL wrap_no_match got=%h required=%h", d2, e.data);
    end
  endtask

  task automatic test_slverr();
    logic [31:0] d; logic [1:0] r; bit l; rexp_t e;
    logic [15:0] regs[5] = '{16'h1000, 16'h1004, 16'h1008, 16'h100C, 16'h1010};
    bq.push_back(RESP_SLVERR);
    axi_write(16'h1020, 32'hFFFF_FFFF, 4'hF, r, l);
    checks++;
    if (r !== bq.pop_front()) begin failures++; $display("FAIL bad_write_resp got=%b required=10", r); end
    rq.push_back('{32'd0, RESP_SLVERR});
    axi_read(16'h103C, d, r, l);
    e = rq.pop_front();
    checks++;
    if ({d, r} !== {e.data, e.resp}) begin
      failures++; $display("FAIL bad_read got=%h/%b required=%h/%b", d, r, e.data, e.resp);
    end
    rq.push_back('{32'h0, RESP_OKAY});
    rq.push_back('{32'h0, RESP_OKAY});
    rq.push_back('{32'h1, RESP_OKAY});
    rq.push_back('{32'h10, RESP_OKAY});
    rq.push_back('{32'h0, RESP_OKAY});
    for (int i = 0; i < 5; i++) begin
      axi_read(regs[i], d, r, l);
      e = rq.pop_front();
      checks++;
      if ({d, r} !== {e.data, e.resp}) begin
        failures++; $display("FAIL reg_untouched idx=%0d got=%h required=%h", i, d, e.data);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] d; logic [1:0] r; bit l; rexp_t e;
    awaddr = 16'h100C; wdata = 32'hA5A5_0000; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    araddr = 16'h1008; arvalid = 1;
    step(); awvalid = 0; wvalid = 0; arvalid = 0;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({bvalid, bresp, awready, wready, rvalid, rresp, arready, rdata} !==
          {1'b1, RESP_OKAY, 2'b00, 1'b1, RESP_OKAY, 1'b0, 32'd1}) begin
        failures++;
        $display("FAIL hold_resp cyc=%0d b=%b/%b awr=%b r=%b/%b/%h arr=%b", i, bvalid, bresp,
                 awready, rvalid, rresp, rdata, arready);
      end
      step();
    end
    bready = 1; rready = 1; step(); bready = 0; rready = 0;
    checks++;
    if ({bvalid, rvalid, awready, arready} !== 4'b0011) begin
      failures++; $display("FAIL release_resp got=%b required=0011", {bvalid, rvalid, awready, arready});
    end
    rq.push_back('{32'hA5A5_0000, RESP_OKAY});
    axi_read(16'h100C, d, r, l);
    e = rq.pop_front();
    checks++;
    if ({d, r} !== {e.data, e.resp}) begin
      failures++; $display("FAIL held_write_data got=%h required=%h", d, e.data);
    end
  endtask

  task automatic test_reset_midop();
    logic [31:0] d; logic [1:0] r; bit l; rexp_t e;
    awaddr = 16'h1008; awvalid = 1; araddr = 16'h100C; arvalid = 1;
    step(); awvalid = 0; arvalid = 0;
    rst = 1; #1;
    checks++;
    if ({bvalid, rvalid, awready, wready, arready} !== 5'b00111) begin
      failures++; $display("FAIL midop_reset got=%b required=00111", {bvalid, rvalid, awready, wready, arready});
    end
    step(); rst = 0;
    wdata = 32'h55; wstrb = 4'hF; wvalid = 1;
    step(); wvalid = 0; step(); step();
    checks++;
    if ({bvalid, rvalid} !== 2'b00) begin
      failures++; $display("FAIL stale_resp got=%b required=00", {bvalid, rvalid});
    end
    rst = 1; step(); rst = 0; step();
    rq.push_back('{COMPARE_RST, RESP_OKAY});
    axi_read(16'h100C, d, r, l);
    e = rq.pop_front();
    checks++;
    if ({d, r} !== {e.data, e.resp}) begin
      failures++; $display("FAIL compare_after_reset got=%h required=%h", d, e.data);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_read_after_reset();
    test_w_before_aw();
    test_wstrb();
    test_match_irq();
    test_wrap();
    test_slverr();
    test_backpressure();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
